// File: rtl/cmsdk_ahb_master_arbiter.sv
// cmsdk_ahb_master_arbiter
//   Request/grant arbiter that lets up to four AHB-Lite masters share one system bus.
//   It uses rotating priority, holds the bus for locked sequences, never breaks a
//   burst, and caps how long one master may hold the bus while others are waiting.
//   It also produces the master-select codes that steer the bus muxes.
//
// Ports
//   HCLK, HRESET      clock and synchronous active-high reset
//   req[N]            per-master bus request (level)
//   lock[N]           per-master locked-sequence request, only valid together with req
//   HTRANS, HREADY    transfer type of the current address-phase owner, and bus ready
//   grant[N]          registered one-hot grant
//   hmaster           index of the master that owns the address phase
//   hmaster_data      index of the master that owns the data phase
//   hmastlock         the current address phase is locked
//   tenure_expired    the owner has used up its tenure while others are waiting
module cmsdk_ahb_master_arbiter #(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16,
  parameter int unsigned TW             = 5
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [1:0]             hmaster,
  output logic [1:0]             hmaster_data,
  output logic                   hmastlock,
  output logic                   tenure_expired
);

  localparam logic [1:0]             HtransIdle   = 2'b00;
  localparam logic [1:0]             HtransNonseq = 2'b10;
  localparam logic [1:0]             DefIdx       = 2'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DefGrant     =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [TW-1:0]          MaxTen       = TW'(MAX_TENURE);

  typedef enum logic [1:0] {
    StOwned    = 2'd0,
    StHandover = 2'd1,
    StLocked   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  // ptr_q is both the last-winner pointer and the index of the granted master:
  // a switch always moves the grant to the winner, so the two never differ.
  logic [1:0]             ptr_q, ptr_d;
  logic [1:0]             hmaster_q, hmaster_d;
  logic [1:0]             hdata_q, hdata_d;
  logic                   lock_q, lock_d;
  logic [TW-1:0]          cnt_q, cnt_d;

  logic [3:0] req_v;
  logic [3:0] lock_v;
  logic       own_req;
  logic       own_lock;
  logic       others_req;
  logic       addr_ok;
  logic       beat;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Widen to four bits so indexing by a 2-bit master number is always in range.
  // Bits at index >= NUM_MASTERS are zero and therefore never win.
  assign req_v  = 4'(req);
  assign lock_v = 4'(lock);

  assign own_req    = req_v[ptr_q];
  assign own_lock   = own_req & lock_v[ptr_q];
  assign others_req = |(req_v & ~(4'b0001 << ptr_q));
  assign addr_ok    = (HTRANS == HtransIdle) || (HTRANS == HtransNonseq);
  assign beat       = HTRANS[1];  // NONSEQ or SEQ

  assign tenure_expired = (MAX_TENURE != 0) && (cnt_q == MaxTen);

  // Rotating priority: search from the master after the last winner, wrapping.
  // The current owner is therefore considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = 2'((32'(ptr_q) + i) % NUM_MASTERS);
      if (!win_found && req_v[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    hmaster_d = hmaster_q;
    hdata_d   = hdata_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;

    // Wait states freeze everything, including the grant.
    if (HREADY) begin
      hdata_d   = hmaster_q;
      hmaster_d = ptr_q;

      case (state_q)
        StOwned: begin
          if (own_lock && (HTRANS == HtransNonseq)) begin
            lock_d  = 1'b1;
            state_d = StLocked;
          end else if (addr_ok && (!own_req || (tenure_expired && !own_lock)) &&
                       win_found && (win_idx != ptr_q)) begin
            for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
              grant_d[i] = (2'(i) == win_idx);
            end
            ptr_d   = win_idx;
            state_d = StHandover;
          end
        end
        // hmaster picks up the new owner on this edge.
        StHandover: state_d = StOwned;
        // Leaving the lock is the only action on this edge; arbitration waits.
        StLocked: begin
          if (!own_lock && addr_ok) begin
            lock_d  = 1'b0;
            state_d = StOwned;
          end
        end
        default: state_d = StOwned;
      endcase

      if ((ptr_d != ptr_q) || !others_req) begin
        cnt_d = '0;
      end else if (beat && (cnt_q != MaxTen)) begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StOwned;
      grant_q   <= DefGrant;
      ptr_q     <= DefIdx;
      hmaster_q <= DefIdx;
      hdata_q   <= DefIdx;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      hmaster_q <= hmaster_d;
      hdata_q   <= hdata_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hdata_q;
  assign hmastlock    = lock_q;

endmodule
